freq_divider_prog: RTL and testbench

- Runtime-programmable integer clock divider for the DDFS/VGA DAC clocking path.
- Generalises the fixed 3-bit-select divider to a DIV_W-bit divisor.
- Divisor changes are glitch-free, applied only at a period boundary.
- Provides a one-cycle tick (clock enable), near-50 % duty clk_out, enable/freeze, and phase clear for multi-divider alignment.

---
 rtl/freq_divider_prog.sv | 81 ++++++++
 tb/tb_freq_divider_prog.sv | 112 +++++++++++
 2 files changed

// File: rtl/freq_divider_prog.sv
// Runtime-programmable integer clock divider: N-cycle period, near-50% duty clk_out,
// one-cycle tick on the last count, divisor changes applied only at period boundaries.
module freq_divider_prog #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic             phase_clr,
  output logic             clk_out,
  output logic             tick,
  output logic             load_pending,
  output logic [DIV_W-1:0] div_active
);

  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] shadow;
  logic             wrap;
  logic [DIV_W-1:0] n_wrap;
  logic [DIV_W-1:0] n_next;
  logic [DIV_W-1:0] cnt_next;

  // ceil(n/2), one bit wider so n = 2^DIV_W-1 does not overflow
  function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] n);
    return ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
  endfunction

  function automatic logic clk_level(input logic [DIV_W-1:0] n, input logic [DIV_W-1:0] c);
    return (n != '0) && ({1'b0, c} < half_up(n));
  endfunction

  function automatic logic last_count(input logic [DIV_W-1:0] n, input logic [DIV_W-1:0] c);
    return (n != '0) && (c == n - DIV_W'(1));
  endfunction

  always_comb begin
    wrap     = (div_active == '0) || (cnt == div_active - DIV_W'(1)) || phase_clr;
    n_wrap   = div_active;
    if (div_load)
      n_wrap = div_val;
    else if (load_pending)
      n_wrap = shadow;
    n_next   = wrap ? n_wrap : div_active;
    cnt_next = wrap ? '0 : cnt + DIV_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt          <= '0;
      div_active   <= DEF_N;
      shadow       <= DEF_N;
      load_pending <= 1'b0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
    end else begin
      // shadow keeps capturing loads even while frozen
      if (div_load)
        shadow <= div_val;
      if (en) begin
        cnt        <= cnt_next;
        div_active <= n_next;
        clk_out    <= clk_level(n_next, cnt_next);
        tick       <= last_count(n_next, cnt_next);
        if (wrap)
          load_pending <= 1'b0;
        else if (div_load)
          load_pending <= 1'b1;
      end else begin
        tick <= 1'b0;
        if (div_load)
          load_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_divider_prog.sv
// Randomized bench for freq_divider_prog against a period-position reference model.
module tb_freq_divider_prog;

  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 4;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             phase_clr = 1'b0;
  logic             clk_out;
  logic             tick;
  logic             load_pending;
  logic [DIV_W-1:0] div_active;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: position inside the current period and the divisor in force
  int m_pos, m_n, m_shadow, m_pend, m_clk, m_tick;

  freq_divider_prog #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .phase_clr(phase_clr), .clk_out(clk_out), .tick(tick),
    .load_pending(load_pending), .div_active(div_active)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit end_of_period;
    if (rst) begin
      m_pos = 0; m_n = DEF_DIV; m_shadow = DEF_DIV; m_pend = 0; m_clk = 0; m_tick = 0;
      return;
    end
    if (!en) begin
      m_tick = 0;
      if (div_load) begin m_shadow = int'(div_val); m_pend = 1; end
      return;
    end
    end_of_period = (m_n == 0) || (m_pos == m_n - 1) || phase_clr;
    if (end_of_period) begin
      if (div_load)    m_n = int'(div_val);
      else if (m_pend) m_n = m_shadow;
      m_pend = 0;
      m_pos  = 0;
    end else begin
      m_pos = m_pos + 1;
      if (div_load) m_pend = 1;
    end
    if (div_load) m_shadow = int'(div_val);
    m_clk  = (m_n != 0 && m_pos < (m_n + 1) / 2) ? 1 : 0;
    m_tick = (m_n != 0 && m_pos == m_n - 1) ? 1 : 0;
  endtask

  task automatic step_and_check();
    @(posedge clk_in);
    #1;
    model_edge();
    chk_val("clk_out", clk_out, m_clk);
    chk_val("tick", tick, m_tick);
    chk_val("load_pending", load_pending, m_pend);
    chk_val("div_active", div_active, m_n);
  endtask

  function automatic logic [DIV_W-1:0] pick_div();
    int r;
    r = $urandom % 20;
    if (r < 11) return DIV_W'($urandom_range(2, 9));
    if (r < 14) return DIV_W'(0);
    if (r < 17) return DIV_W'(1);
    if (r < 19) return DIV_W'($urandom_range(10, 40));
    return '1;
  endfunction

  initial begin
    rst = 1'b1;
    step_and_check();
    step_and_check();
    rst = 1'b0; en = 1'b1;
    // free-run the default divisor
    for (int i = 0; i < 16; i++) step_and_check();

    for (int i = 0; i < 6000; i++) begin
      rst       = ($urandom % 500) == 0;
      en        = ($urandom % 6) != 0;
      phase_clr = ($urandom % 25) == 0;
      div_load  = ($urandom % 10) == 0;
      div_val   = div_load ? pick_div() : DIV_W'($urandom);
      step_and_check();
      // keep huge divisors from dominating the run
      if (m_n > 100 && ($urandom % 60) == 0) begin
        rst = 1'b1;
        step_and_check();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
